heap_array_server: RTL and testbench

//  Responder side of the heap action interface: decodes array operations issued by the program

---
 rtl/heap_array_server.sv | 218 +++++++++++++++++++++
 tb/tb_heap_array_server.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/heap_array_server.sv
// Array-pool responder for the heap action interface: one request in flight,
// executed against a pool of fixed-size word arrays with a per-array length and allocation bit.
module heap_array_server #(
  parameter int ARRAYS = 8,
  parameter int SIZE   = 8,
  parameter int WIDTH  = 12
) (
  input  logic                      clock_i,
  input  logic                      reset_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [7:0]                action_i,
  input  logic [$clog2(ARRAYS)-1:0] array_i,
  input  logic [$clog2(SIZE)-1:0]   index_i,
  input  logic [WIDTH-1:0]          in_data_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [WIDTH-1:0]          out_data_o,
  output logic                      error_o
);

  localparam int AW = $clog2(ARRAYS);
  localparam int IW = $clog2(SIZE);
  localparam int LW = IW + 1;

  localparam logic [7:0] A_NOP    = 8'd0;
  localparam logic [7:0] A_RESET  = 8'd1;
  localparam logic [7:0] A_ALLOC  = 8'd2;
  localparam logic [7:0] A_FREE   = 8'd3;
  localparam logic [7:0] A_READ   = 8'd4;
  localparam logic [7:0] A_WRITE  = 8'd5;
  localparam logic [7:0] A_PUSH   = 8'd6;
  localparam logic [7:0] A_POP    = 8'd7;
  localparam logic [7:0] A_LENGTH = 8'd8;
  localparam logic [7:0] A_RESIZE = 8'd9;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            state_q;
  logic              phase_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [WIDTH-1:0]  out_q;
  logic              err_q;

  logic [7:0]        act_q;
  logic [AW-1:0]     arr_q;
  logic [IW-1:0]     idx_q;
  logic [WIDTH-1:0]  din_q;

  logic [ARRAYS-1:0] alloc_q, alloc_d;
  logic [LW-1:0]     len_q [ARRAYS];
  logic [LW-1:0]     len_d [ARRAYS];

  logic [WIDTH-1:0]  mem [ARRAYS][SIZE];
  logic [WIDTH-1:0]  rd_q;

  logic              accept;
  logic              commit;
  logic              cur_alloc;
  logic [LW-1:0]     cur_len;
  logic [LW-1:0]     pop_len;
  logic [IW-1:0]     rd_idx;
  logic [IW-1:0]     wr_idx;
  logic              wr_en;
  logic              free_found;
  logic [AW-1:0]     free_idx;
  logic [WIDTH-1:0]  res_out;
  logic              res_err;

  assign accept    = (state_q == S_IDLE) && req_valid_i && req_ready_q;
  assign commit    = (state_q == S_EXEC) && phase_q;
  assign cur_alloc = alloc_q[arr_q];
  assign cur_len   = len_q[arr_q];
  assign pop_len   = cur_len - LW'(1);
  assign rd_idx    = (act_q == A_POP) ? pop_len[IW-1:0] : idx_q;

  // Operand latch and synchronous-read RAM; the first EXEC cycle covers the read latency.
  always_ff @(posedge clock_i) begin
    if (accept) begin
      act_q <= action_i;
      arr_q <= array_i;
      idx_q <= index_i;
      din_q <= in_data_i;
    end
    rd_q <= mem[arr_q][rd_idx];
    if (commit && wr_en) mem[arr_q][wr_idx] <= din_q;
  end

  // Decode/execute: next allocation map, lengths and the response word.
  always_comb begin
    alloc_d    = alloc_q;
    len_d      = len_q;
    wr_en      = 1'b0;
    wr_idx     = idx_q;
    res_out    = '0;
    res_err    = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ARRAYS - 1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        free_found = 1'b1;
        free_idx   = AW'(i);
      end
    end
    case (act_q)
      A_NOP: ;
      A_RESET: begin
        alloc_d = '0;
        for (int i = 0; i < ARRAYS; i++) len_d[i] = '0;
      end
      A_ALLOC: begin
        if (!free_found) res_err = 1'b1;
        else begin
          alloc_d[free_idx] = 1'b1;
          len_d[free_idx]   = '0;
          res_out           = WIDTH'(free_idx);
        end
      end
      A_FREE: begin
        if (!cur_alloc) res_err = 1'b1;
        else begin
          alloc_d[arr_q] = 1'b0;
          len_d[arr_q]   = '0;
        end
      end
      A_READ: begin
        if (!cur_alloc || LW'(idx_q) >= cur_len) res_err = 1'b1;
        else res_out = rd_q;
      end
      A_WRITE: begin
        if (!cur_alloc || LW'(idx_q) >= LW'(SIZE)) res_err = 1'b1;
        else begin
          wr_en = 1'b1;
          if (LW'(idx_q) >= cur_len) len_d[arr_q] = LW'(idx_q) + LW'(1);
        end
      end
      A_PUSH: begin
        if (!cur_alloc || cur_len >= LW'(SIZE)) res_err = 1'b1;
        else begin
          wr_en        = 1'b1;
          wr_idx       = cur_len[IW-1:0];
          len_d[arr_q] = cur_len + LW'(1);
          res_out      = WIDTH'(cur_len + LW'(1));
        end
      end
      A_POP: begin
        if (!cur_alloc || cur_len == '0) res_err = 1'b1;
        else begin
          len_d[arr_q] = pop_len;
          res_out      = rd_q;
        end
      end
      A_LENGTH: begin
        if (!cur_alloc) res_err = 1'b1;
        else res_out = WIDTH'(cur_len);
      end
      A_RESIZE: begin
        if (!cur_alloc || din_q > WIDTH'(SIZE)) res_err = 1'b1;
        else len_d[arr_q] = din_q[LW-1:0];
      end
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      out_q        <= '0;
      err_q        <= 1'b0;
      alloc_q      <= '0;
      for (int i = 0; i < ARRAYS; i++) len_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            phase_q     <= 1'b0;
            state_q     <= S_EXEC;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
          end else begin
            alloc_q      <= alloc_d;
            len_q        <= len_d;
            out_q        <= res_out;
            err_q        <= res_err;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            out_q        <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign out_data_o   = out_q;
  assign error_o      = err_q;

endmodule

// File: tb/tb_heap_array_server.sv
// Scoreboard bench for heap_array_server: expected responses are queued when a
// request is issued and compared when the response handshake occurs.
module tb_heap_array_server;

  localparam int ARRAYS = 8;
  localparam int SIZE   = 8;
  localparam int WIDTH  = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [7:0]       action = '0;
  logic [2:0]       array = '0;
  logic [2:0]       index = '0;
  logic [WIDTH-1:0] in_data = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             error;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] out;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    tests = 0;
  int    fails = 0;

  heap_array_server #(.ARRAYS(ARRAYS), .SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clock_i     (clk),
    .reset_ni    (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .action_i    (action),
    .array_i     (array),
    .index_i     (index),
    .in_data_i   (in_data),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .out_data_o  (out_data),
    .error_o     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "/rdy"}, 32'(req_ready), 32'd1);
  endtask

  // Issue one request; optionally stall resp_ready for 'hold' cycles while
  // a competing request is presented, then take the response.
  task automatic txn(input string tag, input logic [7:0] act, input int arr, input int idx,
                     input int dat, input int eout, input bit eerr, input int hold = 0);
    int    n;
    exp_t  e;
    string t;
    exp_t  ne;
    ne.err = eerr;
    ne.out = WIDTH'(eout);
    sb_q.push_back(ne);
    tag_q.push_back(tag);
    wait_ready(tag);
    action    = act;
    array     = 3'(arr);
    index     = 3'(idx);
    in_data   = WIDTH'(dat);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    action    = 8'($urandom_range(0, 255));
    array     = 3'($urandom_range(0, 7));
    index     = 3'($urandom_range(0, 7));
    in_data   = WIDTH'($urandom_range(0, 4095));
    n = 0;
    while (!resp_valid && n < 10) begin
      step();
      n++;
    end
    check({tag, "/lat"}, 32'(n), 32'd2);
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, "/out"}, 32'(out_data), 32'(e.out));
    check({t, "/err"}, 32'(error), 32'(e.err));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      action    = 8'd2;
      step();
      check({t, "/hold_vld"}, 32'(resp_valid), 32'd1);
      check({t, "/hold_out"}, 32'(out_data), 32'(e.out));
      check({t, "/hold_err"}, 32'(error), 32'(e.err));
      check({t, "/hold_rdy"}, 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    step();
    step();
    check("rst/req_ready", 32'(req_ready), 32'd0);
    check("rst/resp_valid", 32'(resp_valid), 32'd0);
    check("rst/out_data", 32'(out_data), 32'd0);
    check("rst/error", 32'(error), 32'd0);
    rst_n = 1'b1;

    // Reset asserted while a request is executing.
    wait_ready("midrst");
    action    = 8'd2;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midrst/resp_valid", 32'(resp_valid), 32'd0);
    check("midrst/req_ready", 32'(req_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    wait_ready("midrst_rel");
    txn("alloc_after_rst", 8'd2, 0, 0, 0, 0, 1'b0);

    for (int i = 1; i < ARRAYS; i++) txn("alloc_seq", 8'd2, 0, 0, 0, i, 1'b0);
    txn("alloc_full", 8'd2, 0, 0, 0, 0, 1'b1);
    txn("free3", 8'd3, 3, 0, 0, 0, 1'b0);
    txn("realloc3", 8'd2, 0, 0, 0, 3, 1'b0);

    txn("push5", 8'd6, 0, 0, 5, 1, 1'b0);
    txn("push7", 8'd6, 0, 0, 7, 2, 1'b0);
    txn("len2", 8'd8, 0, 0, 0, 2, 1'b0);
    txn("pop7", 8'd7, 0, 0, 0, 7, 1'b0);
    txn("pop5", 8'd7, 0, 0, 0, 5, 1'b0);
    txn("pop_empty", 8'd7, 0, 0, 0, 0, 1'b1);
    txn("len0", 8'd8, 0, 0, 0, 0, 1'b0);

    txn("write5", 8'd5, 0, 5, 12'hABC, 0, 1'b0);
    txn("len6", 8'd8, 0, 0, 0, 6, 1'b0);
    txn("read5", 8'd4, 0, 5, 0, 12'hABC, 1'b0);
    txn("read6_oob", 8'd4, 0, 6, 0, 0, 1'b1);
    txn("free1", 8'd3, 1, 0, 0, 0, 1'b0);
    txn("read_free", 8'd4, 1, 0, 0, 0, 1'b1);
    txn("write_free", 8'd5, 1, 0, 12'h123, 0, 1'b1);
    txn("free_free", 8'd3, 1, 0, 0, 0, 1'b1);

    txn("resize0", 8'd9, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < SIZE; i++) txn("push_fill", 8'd6, 0, 0, 10 + i, i + 1, 1'b0);
    txn("push_full", 8'd6, 0, 0, 99, 0, 1'b1);
    txn("len8", 8'd8, 0, 0, 0, 8, 1'b0);
    txn("resize9", 8'd9, 0, 0, 9, 0, 1'b1);
    txn("len8_kept", 8'd8, 0, 0, 0, 8, 1'b0);
    txn("pop17", 8'd7, 0, 0, 0, 17, 1'b0);
    txn("resize0b", 8'd9, 0, 0, 0, 0, 1'b0);
    txn("len0b", 8'd8, 0, 0, 0, 0, 1'b0);

    txn("act200_hold", 8'd200, 0, 0, 0, 0, 1'b1, 5);
    txn("len_a1_free", 8'd8, 1, 0, 0, 0, 1'b1);

    txn("reset_act", 8'd1, 0, 0, 0, 0, 1'b0);
    txn("alloc_post_reset", 8'd2, 0, 0, 0, 0, 1'b0);
    txn("len_fresh", 8'd8, 0, 0, 0, 0, 1'b0);
    txn("read_fresh", 8'd4, 0, 5, 0, 0, 1'b1);
    txn("resize6", 8'd9, 0, 0, 6, 0, 1'b0);
    txn("read_stale", 8'd4, 0, 5, 0, 15, 1'b0);
    txn("alloc_next", 8'd2, 0, 0, 0, 1, 1'b0);
    txn("nop", 8'd0, 0, 0, 0, 0, 1'b0);
    txn("act10", 8'd10, 0, 0, 0, 0, 1'b1);
    txn("len_a7_free", 8'd8, 7, 0, 0, 0, 1'b1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
